// File: rtl/cpu_sequencer.sv
// Eight-phase fetch/execute sequencer and control decoder for the 8-bit
// accumulator CPU. Steps INST_ADDR..STORE, decodes memory/IR/PC/ACC strobes
// from phase, opcode and the ALU zero flag, handles HLT/resume and counts
// retired instructions.
module cpu_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             resume,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             halt,
  output logic             ld_pc,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic [2:0]       phase,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  phase_t           state, state_nx;
  logic             halted_q, halted_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             aluop;

  assign aluop     = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
  assign phase     = state;
  assign halted    = halted_q;
  assign instr_cnt = cnt_q;

  // State register: phase, halted flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INST_ADDR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nx;
      halted_q <= halted_nx;
      cnt_q    <= cnt_nx;
    end
  end

  // Next-state: advance one phase per enabled cycle, HLT parks at phase 0.
  always_comb begin
    state_nx  = state;
    halted_nx = halted_q;
    cnt_nx    = cnt_q;
    if (halted_q) begin
      if (resume) begin
        halted_nx = 1'b0;
        state_nx  = INST_ADDR;
      end
    end else if (enable) begin
      unique case (state)
        INST_ADDR:  state_nx = INST_FETCH;
        INST_FETCH: state_nx = INST_LOAD;
        INST_LOAD:  state_nx = IDLE;
        IDLE:       state_nx = OP_ADDR;
        OP_ADDR: begin
          if (opcode == OP_HLT) begin
            halted_nx = 1'b1;
            state_nx  = INST_ADDR;
            cnt_nx    = cnt_q + CNT_W'(1);
          end else begin
            state_nx  = OP_FETCH;
          end
        end
        OP_FETCH:   state_nx = ALU_OP;
        ALU_OP:     state_nx = STORE;
        STORE: begin
          state_nx = INST_ADDR;
          cnt_nx   = cnt_q + CNT_W'(1);
        end
        default:    state_nx = INST_ADDR;
      endcase
    end
  end

  // Output decode: levels follow phase; strobes are gated by enable; halted
  // overrides everything except the PC address select.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    unique case (state)
      INST_ADDR:  sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == OP_HLT);
      end
      OP_FETCH:   rd = aluop;
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      STORE: begin
        rd     = aluop;
        inc_pc = (opcode == OP_JMP);
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
        ld_ac  = aluop;
        wr     = (opcode == OP_STO);
      end
      default: sel = 1'b1;
    endcase
    if (!enable) begin
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      halt   = 1'b0;
    end
    if (halted_q) begin
      sel    = 1'b1;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed instruction walks plus randomized
// enable/resume/reset/opcode traffic, compared every cycle against a
// behavioural model of the phase/halt/retire rules. A second instance with
// CNT_W=4 shares the stimulus to exercise counter wrap.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, enable, resume, zero;
  logic [2:0]  opcode;
  logic        sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, halted;
  logic [2:0]  phase;
  logic [15:0] instr_cnt;
  logic        sel4, rd4, ld_ir4, inc_pc4, halt4, ld_pc4, data_e4, ld_ac4, wr4, halted4;
  logic [2:0]  phase4;
  logic [3:0]  instr_cnt4;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ph;
  bit          m_halted;
  int unsigned m_cnt;
  logic [2:0]  cur_op;

  cpu_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .resume(resume),
    .opcode(opcode), .zero(zero), .sel(sel), .rd(rd), .ld_ir(ld_ir),
    .inc_pc(inc_pc), .halt(halt), .ld_pc(ld_pc), .data_e(data_e),
    .ld_ac(ld_ac), .wr(wr), .phase(phase), .halted(halted),
    .instr_cnt(instr_cnt)
  );

  cpu_sequencer #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .resume(resume),
    .opcode(opcode), .zero(zero), .sel(sel4), .rd(rd4), .ld_ir(ld_ir4),
    .inc_pc(inc_pc4), .halt(halt4), .ld_pc(ld_pc4), .data_e(data_e4),
    .ld_ac(ld_ac4), .wr(wr4), .phase(phase4), .halted(halted4),
    .instr_cnt(instr_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} from the phase table.
  function automatic logic [8:0] exp_outs(input int ph, input bit hl, input bit en,
                                          input logic [2:0] op, input bit z);
    bit s = 0, r = 0, li = 0, ip = 0, h = 0, lp = 0, de = 0, la = 0, w = 0;
    bit alu = (op >= 3'd2 && op <= 3'd5);
    if (hl) return 9'b1_0000_0000;
    case (ph)
      0: s = 1;
      1: begin s = 1; r = 1; end
      2, 3: begin s = 1; r = 1; li = 1; end
      4: begin ip = 1; h = (op == 3'd0); end
      5: r = alu;
      6: begin r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); de = (op == 3'd6); end
      default: begin
        r = alu; ip = (op == 3'd7); lp = (op == 3'd7); de = (op == 3'd6);
        la = alu; w = (op == 3'd6);
      end
    endcase
    if (!en) begin li = 0; ip = 0; lp = 0; la = 0; w = 0; h = 0; end
    return {s, r, li, ip, h, lp, de, la, w};
  endfunction

  task automatic step(input bit en, input bit res, input logic [2:0] op,
                      input bit z, input bit rn);
    enable = en; resume = res; opcode = op; zero = z; rst_n = rn;
    #1;
    check("outs", {23'b0, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr},
          {23'b0, exp_outs(m_ph, m_halted, en, op, z)});
    check("outs4", {23'b0, sel4, rd4, ld_ir4, inc_pc4, halt4, ld_pc4, data_e4, ld_ac4, wr4},
          {23'b0, exp_outs(m_ph, m_halted, en, op, z)});
    check("phase", {29'b0, phase}, m_ph);
    check("halted", {31'b0, halted}, {31'b0, m_halted});
    check("cnt16", {16'b0, instr_cnt}, m_cnt % 65536);
    check("cnt4", {28'b0, instr_cnt4}, m_cnt % 16);
    @(posedge clk);
    if (!rn) begin
      m_ph = 0; m_halted = 0; m_cnt = 0;
    end else if (m_halted) begin
      if (res) begin m_halted = 0; m_ph = 0; end
    end else if (en) begin
      if (m_ph == 4 && op == 3'd0) begin
        m_halted = 1; m_ph = 0; m_cnt++;
      end else if (m_ph == 7) begin
        m_ph = 0; m_cnt++;
      end else begin
        m_ph++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [2:0] op, input bit z);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, op, z, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; resume = 1'b0; opcode = 3'd0; zero = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_ph = 0; m_halted = 0; m_cnt = 0;
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);

    run(8, 3'd2, 1'b0);                       // ADD
    run(8, 3'd1, 1'b1);                       // SKZ, zero set
    run(8, 3'd1, 1'b0);                       // SKZ, zero clear
    run(8, 3'd7, 1'b0);                       // JMP
    run(7, 3'd6, 1'b0);                       // STO up to phase 7
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd6, 1'b0, 1'b1);
    run(1, 3'd6, 1'b0);

    run(5, 3'd0, 1'b0);                       // HLT
    for (int i = 0; i < 10; i++)
      step(1'($urandom), 1'b0, 3'($urandom), 1'($urandom), 1'b1);
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);        // resume with enable low

    run(4, 3'd0, 1'b0);                       // HLT with enable dropped in phase 4
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    run(1, 3'd0, 1'b0);
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b1);

    run(5, 3'd2, 1'b0);                       // reset in phase 5
    step(1'b1, 1'b0, 3'd2, 1'b0, 1'b0);

    run(16 * 8, 3'd2, 1'b0);                  // 16 instructions: 4-bit counter wraps

    cur_op = 3'd2;
    for (int i = 0; i < 3000; i++) begin
      if (m_halted || m_ph <= 2) cur_op = 3'($urandom);
      step(($urandom % 4) != 0, ($urandom % 8) == 0, cur_op, 1'($urandom),
           ($urandom % 100) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
